// File: rtl/qcl_swpo_seq_pkg.sv
// ---------------------------------------------------------------------------
// qcl_swpo_seq_pkg
// Shared types and helpers for the frame sequencer.
//   state_e      : sequencer FSM states (IDLE / FILL / FULL)
//   clamp_len()  : maps a requested frame length of 0 or > els to els
//   safe_clog2() : ceil(log2(n)) that never returns less than 1
// ---------------------------------------------------------------------------
package qcl_swpo_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_FULL = 2'd2
    } state_e;

    function automatic int unsigned clamp_len(input int unsigned req, input int unsigned els);
        return ((req == 0) || (req > els)) ? els : req;
    endfunction

    function automatic int unsigned safe_clog2(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/qcl_swpo.sv
// ---------------------------------------------------------------------------
// qcl_swpo
// Addressed serial-in / parallel-out register bank. Each cycle v_i is high,
// data_i is written into element addr_i. Every element is visible at once on
// data_o (element i at bits [i*width_p +: width_p]).
//   clk_i   : clock, rising edge
//   reset_i : synchronous active-high reset, clears every element
//   v_i     : write enable
//   addr_i  : element to write
//   data_i  : word to write
//   v_o     : registered copy of v_i (a write landed last cycle)
//   data_o  : all elements, registered
// ---------------------------------------------------------------------------
module qcl_swpo #(
    parameter int width_p      = 8,
    parameter int els_p        = 4,
    parameter int addr_width_p = 2
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       v_i,
    input  logic [addr_width_p-1:0]    addr_i,
    input  logic [width_p-1:0]         data_i,
    output logic                       v_o,
    output logic [els_p*width_p-1:0]   data_o
);

    logic v_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            v_q <= 1'b0;
        end else begin
            v_q <= v_i;
        end
    end

    assign v_o = v_q;

    // The parallel output has to be visible all at once, so each element is
    // its own register with a decoded write enable.
    for (genvar gi = 0; gi < els_p; gi++) begin : g_el
        logic [width_p-1:0] el_q;

        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                el_q <= '0;
            end else if (v_i && (addr_i == addr_width_p'(gi))) begin
                el_q <= data_i;
            end
        end

        assign data_o[gi*width_p +: width_p] = el_q;
    end

endmodule

// File: rtl/qcl_swpo_seq.sv
// ---------------------------------------------------------------------------
// qcl_swpo_seq
// Frame sequencer in front of a qcl_swpo register bank. Accepts words over a
// valid/ready handshake, writes them to addresses 0,1,2,... and, when the
// frame closes (length reached or flush), presents the bank as one parallel
// frame with a length tag until the consumer takes it with yumi_i.
//   clk_i     : clock, rising edge
//   reset_i   : synchronous active-high reset
//   cfg_len_i : requested frame length, sampled on the first word of a frame
//   v_i       : input word valid
//   data_i    : input word
//   ready_o   : a word can be accepted this cycle
//   flush_i   : close the current partial frame
//   v_o       : frame valid
//   data_o    : parallel frame, element i = i-th word
//   len_o     : number of valid elements in data_o
//   yumi_i    : consumer takes the frame (only while v_o = 1)
// ---------------------------------------------------------------------------
module qcl_swpo_seq
    import qcl_swpo_seq_pkg::*;
#(
    parameter  int width_p       = 8,
    parameter  int els_p         = 4,
    localparam int len_width_lp  = safe_clog2(els_p + 1),
    localparam int addr_width_lp = safe_clog2(els_p)
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [len_width_lp-1:0]   cfg_len_i,
    input  logic                      v_i,
    input  logic [width_p-1:0]        data_i,
    output logic                      ready_o,
    input  logic                      flush_i,
    output logic                      v_o,
    output logic [els_p*width_p-1:0]  data_o,
    output logic [len_width_lp-1:0]   len_o,
    input  logic                      yumi_i
);

    localparam logic [len_width_lp-1:0] one_lp = len_width_lp'(1);

    state_e                    state_q;
    logic [len_width_lp-1:0]   cnt_q;
    logic [len_width_lp-1:0]   len_q;
    logic [len_width_lp-1:0]   len_o_q;
    logic                      v_q;

    logic                      accept;
    logic [len_width_lp-1:0]   cfg_len_clamped;
    logic [len_width_lp-1:0]   cnt_inc;
    logic                      bank_v_unused;

    // ready drops combinationally with reset so nothing is taken in a reset cycle.
    assign ready_o = (state_q != ST_FULL) & ~reset_i;
    assign accept  = v_i & ready_o;

    assign cfg_len_clamped = len_width_lp'(clamp_len(int'(cfg_len_i), els_p));
    assign cnt_inc         = cnt_q + one_lp;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            len_o_q <= '0;
            v_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // A flush with no word in IDLE is ignored: no empty frames.
                    if (accept) begin
                        cnt_q <= one_lp;
                        len_q <= cfg_len_clamped;
                        if ((cfg_len_clamped == one_lp) || flush_i) begin
                            state_q <= ST_FULL;
                            len_o_q <= one_lp;
                            v_q     <= 1'b1;
                        end else begin
                            state_q <= ST_FILL;
                        end
                    end
                end
                ST_FILL: begin
                    if (accept) begin
                        cnt_q <= cnt_inc;
                        // The word accepted alongside a flush belongs to the frame.
                        if ((cnt_q == (len_q - one_lp)) || flush_i) begin
                            state_q <= ST_FULL;
                            len_o_q <= cnt_inc;
                            v_q     <= 1'b1;
                        end
                    end else if (flush_i) begin
                        state_q <= ST_FULL;
                        len_o_q <= cnt_q;
                        v_q     <= 1'b1;
                    end
                end
                ST_FULL: begin
                    if (yumi_i) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        v_q     <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    v_q     <= 1'b0;
                end
            endcase
        end
    end

    assign v_o   = v_q;
    assign len_o = len_o_q;

    // cnt_q never exceeds els_p-1 at a write, so truncation to the bank
    // address width loses nothing.
    qcl_swpo #(
        .width_p      (width_p),
        .els_p        (els_p),
        .addr_width_p (addr_width_lp)
    ) bank (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (accept),
        .addr_i  (cnt_q[addr_width_lp-1:0]),
        .data_i  (data_i),
        .v_o     (bank_v_unused),
        .data_o  (data_o)
    );

    // Taking a frame that is not being offered is a consumer bug.
    yumi_only_when_valid_a : assert property (
        @(posedge clk_i) disable iff (reset_i) yumi_i |-> v_q
    );

endmodule

// File: tb/tb_qcl_swpo_seq.sv
module tb_qcl_swpo_seq;

    localparam int W   = 8;
    localparam int ELS = 4;
    localparam int LW  = 3;

    logic            clk = 1'b0;
    logic            reset_i;
    logic [LW-1:0]   cfg_len_i;
    logic            v_i;
    logic [W-1:0]    data_i;
    logic            flush_i;
    logic            yumi_i;
    logic            ready_o;
    logic            v_o;
    logic [ELS*W-1:0] data_o;
    logic [LW-1:0]   len_o;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: words of the frame being collected, plus the bank
    // contents as the consumer should see them once a frame is presented.
    bit            m_full;
    logic [W-1:0]  m_words[$];
    int            m_target;
    logic [W-1:0]  m_mem[ELS];
    int            m_len;

    qcl_swpo_seq #(.width_p(W), .els_p(ELS)) dut (
        .clk_i     (clk),
        .reset_i   (reset_i),
        .cfg_len_i (cfg_len_i),
        .v_i       (v_i),
        .data_i    (data_i),
        .ready_o   (ready_o),
        .flush_i   (flush_i),
        .v_o       (v_o),
        .data_o    (data_o),
        .len_o     (len_o),
        .yumi_i    (yumi_i)
    );

    always #5 clk = ~clk;

    function automatic logic [ELS*W-1:0] exp_data();
        logic [ELS*W-1:0] r;
        for (int i = 0; i < ELS; i++) r[i*W +: W] = m_mem[i];
        return r;
    endfunction

    function automatic logic [W-1:0] elem(input int i);
        return data_o[i*W +: W];
    endfunction

    // Drive one cycle of inputs, advance the model across the edge, settle.
    task automatic step(input bit v, input logic [W-1:0] d, input logic [LW-1:0] cfg,
                        input bit fl, input bit yu, input bit rst);
        bit acc;
        reset_i   = rst;
        v_i       = v;
        data_i    = d;
        cfg_len_i = cfg;
        flush_i   = fl;
        yumi_i    = yu;
        acc = v && !m_full && !rst;
        @(posedge clk);
        if (rst) begin
            m_full = 0;
            m_words.delete();
            m_len = 0;
            for (int i = 0; i < ELS; i++) m_mem[i] = '0;
        end else if (m_full) begin
            if (yu) begin
                m_full = 0;
                m_words.delete();
            end
        end else begin
            if (acc) begin
                if (m_words.size() == 0) m_target = (cfg == 0 || cfg > ELS) ? ELS : int'(cfg);
                m_words.push_back(d);
            end
            if (m_words.size() > 0 && (m_words.size() == m_target || fl)) begin
                for (int i = 0; i < m_words.size(); i++) m_mem[i] = m_words[i];
                m_len  = m_words.size();
                m_full = 1;
            end
        end
        #1;
    endtask

    task automatic idle();
        step(0, '0, '0, 0, 0, 0);
    endtask

    task automatic test_reset();
        step(0, '0, '0, 0, 0, 1);
        step(0, '0, '0, 0, 0, 1);
        compared++; if (v_o !== 1'b0) begin mismatched++; $display("FAIL reset_v_o: got %b expected 0", v_o); end
        compared++; if (ready_o !== 1'b0) begin mismatched++; $display("FAIL reset_ready_o: got %b expected 0", ready_o); end
        compared++; if (len_o !== '0) begin mismatched++; $display("FAIL reset_len_o: got %0d expected 0", len_o); end
        compared++; if (data_o !== '0) begin mismatched++; $display("FAIL reset_data_o: got %h expected 0", data_o); end
        idle();
        compared++; if (ready_o !== 1'b1) begin mismatched++; $display("FAIL reset_release_ready: got %b expected 1", ready_o); end
        compared++; if (v_o !== 1'b0) begin mismatched++; $display("FAIL reset_release_v: got %b expected 0", v_o); end
    endtask

    task automatic test_full_frame();
        logic [ELS*W-1:0] want;
        want = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
        step(1, 8'hAA, 3'd4, 0, 0, 0);
        step(1, 8'hBB, 3'd4, 0, 0, 0);
        step(1, 8'hCC, 3'd4, 0, 0, 0);
        compared++; if (v_o !== 1'b0) begin mismatched++; $display("FAIL full_early_v: got %b expected 0", v_o); end
        step(1, 8'hDD, 3'd4, 0, 0, 0);
        compared++; if (v_o !== 1'b1) begin mismatched++; $display("FAIL full_v: got %b expected 1", v_o); end
        compared++; if (ready_o !== 1'b0) begin mismatched++; $display("FAIL full_ready: got %b expected 0", ready_o); end
        compared++; if (len_o !== 3'd4) begin mismatched++; $display("FAIL full_len: got %0d expected 4", len_o); end
        compared++; if (data_o !== want) begin mismatched++; $display("FAIL full_data: got %h expected %h", data_o, want); end
        step(0, '0, 3'd4, 0, 1, 0);
        compared++; if (ready_o !== 1'b1) begin mismatched++; $display("FAIL full_ready_after_yumi: got %b expected 1", ready_o); end
        compared++; if (v_o !== 1'b0) begin mismatched++; $display("FAIL full_v_after_yumi: got %b expected 0", v_o); end
    endtask

    task automatic test_back_to_back();
        int next = 1;
        int frames = 0;
        int cycles = 0;
        while ((next <= 6 || m_full) && cycles < 40) begin
            if (m_full) begin
                step(1, W'(next), 3'd2, 0, 1, 0);
            end else begin
                step(1, W'(next), 3'd2, 0, 0, 0);
                next++;
            end
            cycles++;
            compared++; if (v_o !== m_full) begin mismatched++; $display("FAIL b2b_v cyc%0d: got %b expected %b", cycles, v_o, m_full); end
            compared++; if (ready_o !== !m_full) begin mismatched++; $display("FAIL b2b_ready cyc%0d: got %b expected %b", cycles, ready_o, !m_full); end
            if (m_full) begin
                compared++; if (len_o !== 3'd2) begin mismatched++; $display("FAIL b2b_len f%0d: got %0d expected 2", frames, len_o); end
                compared++; if (elem(0) !== W'(2*frames+1)) begin mismatched++; $display("FAIL b2b_e0 f%0d: got %0d expected %0d", frames, elem(0), 2*frames+1); end
                compared++; if (elem(1) !== W'(2*frames+2)) begin mismatched++; $display("FAIL b2b_e1 f%0d: got %0d expected %0d", frames, elem(1), 2*frames+2); end
                frames++;
            end
        end
        compared++; if (next <= 6 || m_full) begin mismatched++; $display("FAIL b2b_timeout: got %0d words sent expected 6", next-1); end
    endtask

    task automatic test_flush_with_word();
        step(1, 8'h07, 3'd4, 0, 0, 0);
        step(1, 8'h08, 3'd4, 0, 0, 0);
        step(1, 8'h09, 3'd4, 1, 0, 0);
        compared++; if (v_o !== 1'b1) begin mismatched++; $display("FAIL flush_v: got %b expected 1", v_o); end
        compared++; if (len_o !== 3'd3) begin mismatched++; $display("FAIL flush_len: got %0d expected 3", len_o); end
        compared++; if (elem(0) !== 8'h07 || elem(1) !== 8'h08 || elem(2) !== 8'h09)
            begin mismatched++; $display("FAIL flush_data: got %h expected low three 090807", data_o); end
        compared++; if (elem(3) !== 8'hDD) begin mismatched++; $display("FAIL flush_stale_e3: got %h expected dd", elem(3)); end
    endtask

    task automatic test_hold_full();
        logic [ELS*W-1:0] snap;
        logic [W-1:0] w[4];
        logic [ELS*W-1:0] want;
        snap = exp_data();
        for (int i = 0; i < 10; i++) begin
            step(1, W'($urandom), 3'd4, 0, 0, 0);
            compared++; if (ready_o !== 1'b0) begin mismatched++; $display("FAIL hold_ready c%0d: got %b expected 0", i, ready_o); end
            compared++; if (data_o !== snap) begin mismatched++; $display("FAIL hold_data c%0d: got %h expected %h", i, data_o, snap); end
        end
        step(1, 8'hEE, 3'd4, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            w[i] = W'($urandom);
            step(1, w[i], 3'd4, 0, 0, 0);
        end
        want = {w[3], w[2], w[1], w[0]};
        compared++; if (v_o !== 1'b1) begin mismatched++; $display("FAIL hold_next_v: got %b expected 1", v_o); end
        compared++; if (data_o !== want) begin mismatched++; $display("FAIL hold_next_data: got %h expected %h", data_o, want); end
        step(0, '0, '0, 0, 1, 0);
    endtask

    task automatic test_clamp();
        logic [LW-1:0] cfgs[2];
        cfgs[0] = 3'd0;
        cfgs[1] = 3'd7;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) step(1, W'(8'h40 + i), cfgs[k], 0, 0, 0);
            compared++; if (v_o !== 1'b1) begin mismatched++; $display("FAIL clamp_v cfg%0d: got %b expected 1", cfgs[k], v_o); end
            compared++; if (len_o !== 3'd4) begin mismatched++; $display("FAIL clamp_len cfg%0d: got %0d expected 4", cfgs[k], len_o); end
            step(0, '0, '0, 0, 1, 0);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, '0, 3'd4, 1, 0, 0);
            compared++; if (v_o !== 1'b0) begin mismatched++; $display("FAIL idle_flush_v c%0d: got %b expected 0", i, v_o); end
            compared++; if (ready_o !== 1'b1) begin mismatched++; $display("FAIL idle_flush_ready c%0d: got %b expected 1", i, ready_o); end
        end
    endtask

    task automatic test_mid_reset();
        logic [ELS*W-1:0] want;
        want = {8'h44, 8'h33, 8'h22, 8'h11};
        step(1, 8'hA1, 3'd4, 0, 0, 0);
        step(1, 8'hA2, 3'd4, 0, 0, 0);
        step(0, '0, 3'd4, 0, 0, 1);
        compared++; if (v_o !== 1'b0) begin mismatched++; $display("FAIL mrst_v: got %b expected 0", v_o); end
        compared++; if (data_o !== '0) begin mismatched++; $display("FAIL mrst_data: got %h expected 0", data_o); end
        compared++; if (len_o !== '0) begin mismatched++; $display("FAIL mrst_len: got %0d expected 0", len_o); end
        compared++; if (ready_o !== 1'b0) begin mismatched++; $display("FAIL mrst_ready: got %b expected 0", ready_o); end
        idle();
        compared++; if (v_o !== 1'b0) begin mismatched++; $display("FAIL mrst_v_after: got %b expected 0", v_o); end
        step(1, 8'h11, 3'd4, 0, 0, 0);
        step(1, 8'h22, 3'd4, 0, 0, 0);
        step(1, 8'h33, 3'd4, 0, 0, 0);
        step(1, 8'h44, 3'd4, 0, 0, 0);
        compared++; if (len_o !== 3'd4) begin mismatched++; $display("FAIL mrst_new_len: got %0d expected 4", len_o); end
        compared++; if (data_o !== want) begin mismatched++; $display("FAIL mrst_new_data: got %h expected %h", data_o, want); end
        step(0, '0, '0, 0, 1, 0);
    endtask

    task automatic test_random();
        bit v, fl, yu, rst;
        for (int c = 0; c < 500; c++) begin
            v   = ($urandom % 4) != 0;
            fl  = ($urandom % 8) == 0;
            yu  = m_full && (($urandom % 3) == 0);
            rst = ($urandom % 100) == 0;
            step(v, W'($urandom), LW'($urandom % 8), fl, yu, rst);
            compared++; if (v_o !== m_full) begin mismatched++; $display("FAIL rand_v c%0d: got %b expected %b", c, v_o, m_full); end
            compared++; if (ready_o !== (!m_full && !rst)) begin mismatched++; $display("FAIL rand_ready c%0d: got %b expected %b", c, ready_o, !m_full && !rst); end
            if (m_full) begin
                compared++; if (len_o !== LW'(m_len)) begin mismatched++; $display("FAIL rand_len c%0d: got %0d expected %0d", c, len_o, m_len); end
                compared++; if (data_o !== exp_data()) begin mismatched++; $display("FAIL rand_data c%0d: got %h expected %h", c, data_o, exp_data()); end
            end
        end
    endtask

    initial begin
        reset_i = 1'b1; v_i = 1'b0; data_i = '0; cfg_len_i = '0; flush_i = 1'b0; yumi_i = 1'b0;
        m_full = 0; m_target = ELS; m_len = 0;
        for (int i = 0; i < ELS; i++) m_mem[i] = '0;
        test_reset();
        test_full_frame();
        test_back_to_back();
        test_flush_with_word();
        test_hold_full();
        test_clamp();
        test_mid_reset();
        test_random();
        idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/qcl_swpo_seq.md
# qcl_swpo_seq

Frame sequencer for the addressed serial-in/parallel-out register bank. It accepts a stream of words over a valid/ready handshake and generates the write addresses 0, 1, 2, … into the register bank. When a frame completes, it presents the whole bank as one parallel frame with a length tag and holds it stable until the consumer takes it. It sits between a serial producer (e.g. a FIFO or link receiver) and any consumer that needs a full vector of words at once.

## Interface
- width_p, "inv", bits per word
- els_p, "inv", bank depth (maximum frame length), ≥1
- len_width_lp, derived, `BSG_SAFE_CLOG2(els_p+1)`
- addr_width_lp, derived, `BSG_SAFE_CLOG2(els_p)`

- clk_i  in  1  single clock, rising edge
- reset_i  in  1  synchronous, active-high reset
- cfg_len_i  in  len_width_lp  requested frame length; sampled on the first accepted word of each frame
- v_i  in  1  input word valid
- data_i  in  width_p  input word
- ready_o  out  1  sequencer can accept a word this cycle
- flush_i  in  1  close the current partial frame
- v_o  out  1  frame valid
- data_o  out  els_p×width_p  parallel frame; element i is the i-th word of the frame
- len_o  out  len_width_lp  number of valid elements in data_o (1..els_p)
- yumi_i  in  1  consumer takes the frame; legal only while v_o=1

## Operation
- States: IDLE (no words held), FILL (1..len−1 words held), FULL (frame presented).
- Accept rule: accept = v_i & ready_o. ready_o = (state != FULL) & ~reset_i.
- Each accept writes data_i at address cnt_r, then increments cnt_r.
- IDLE, on accept:
  - latch len_r = cfg_len_i; if cfg_len_i is 0 or greater than els_p, len_r = els_p.
  - If len_r = 1, go to FULL; otherwise go to FILL with cnt_r = 1.
- FILL, on accept with cnt_r = len_r−1: go to FULL, len_o = len_r.
- flush_i in FILL: go to FULL with len_o = words held.
  - If an accept happens in the same cycle, that word is included in the frame.
- flush_i in IDLE with no accept: ignored; no empty frames are ever emitted.
- flush_i in IDLE together with an accept: a 1-word frame.
- flush_i in FULL: ignored.
- FULL: v_o = 1; data_o and len_o are stable. On yumi_i go to IDLE with cnt_r = 0.
- yumi_i while v_o = 0: ignored (assertion in simulation).
- Elements at index ≥ len_o keep the previous frame's contents; consumers must use len_o.
- cnt_r width is len_width_lp. The bank write address is cnt_r truncated to addr_width_lp; cnt_r never exceeds els_p−1 at a write.

## Timing
- Reset values: v_o = 0, ready_o = 0 while reset_i = 1, len_o = 0, data_o all zero, state IDLE, cnt_r = 0.
- ready_o = 1 in the first cycle after reset deasserts.
- v_o rises in the cycle after the closing accept or flush.
- ready_o falls in that same cycle.
- No input is accepted in any FULL cycle, including the cycle yumi_i is high.
- ready_o returns in the cycle after yumi_i.
- Peak throughput: one N-word frame every N+1 cycles, when yumi_i is asserted in the first FULL cycle.
- reset_i mid-frame or while FULL: the frame is discarded, the next cycle shows reset values, and no v_o pulse occurs.
- data_o is registered. It reflects all accepted words no later than the cycle v_o rises.

## Structure
- Package qcl_swpo_seq_pkg:
  - state enum (IDLE/FILL/FULL)
  - a length-clamp function (0 or >els_p maps to els_p)
- Storage is one instance of the existing addressed register bank qcl_swpo, with:
  - width_p = width_p
  - els_p = els_p
  - addr_width_p = addr_width_lp
  - v_i = accept
  - addr_i = cnt_r
  - its v_o left unused
- The sequencer owns the FSM, cnt_r, len_r and the output length register.

## Test plan
- els_p=4, cfg_len=4, words A,B,C,D back-to-back -> v_o=1 on cycle 5, data_o={D,C,B,A}, len_o=4, ready_o=0; yumi on cycle 5 -> ready_o=1 on cycle 6.
- cfg_len=2, stream 1..6 with yumi held high -> three frames {2,1},{4,3},{6,5}, each len_o=2, one idle cycle between frames.
- cfg_len=4, send 7,8, then flush_i together with word 9 -> frame len_o=3, elements 0..2 = 7,8,9, element 3 = previous value.
- Hold yumi_i low for 10 cycles in FULL while v_i=1 -> ready_o=0 throughout, data_o unchanged, no words lost after yumi.
- cfg_len=0 and cfg_len=7 with els_p=4 -> both produce len_o=4; a flush in IDLE alone produces no v_o.
- Assert reset_i for 1 cycle after 2 of 4 words -> v_o stays 0 and data_o is zero; a new 4-word frame starts at address 0.
